// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the fully connected output-layer sequencer.
package nn_pkg;

  localparam int unsigned NUM_ROWS   = 10;
  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned WGT_W      = 16;
  localparam int unsigned ACC_W      = 34;
  localparam int unsigned RES_W      = 16;
  localparam int unsigned PROD_W     = PIX_W + 1 + WGT_W;

  localparam int unsigned PIX_AW = 10;
  localparam int unsigned WGT_AW = 13;
  localparam int unsigned ROW_AW = 4;
  localparam int unsigned PAIR_W = PIX_AW - 1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} seq_state_t;

endpackage

// File: rtl/nn_mac_pair.sv
// Dual-lane multiply-accumulate: registered pixel*weight products feeding a cleared
// accumulator, with the scaled and saturated row result as output.
module nn_mac_pair
  import nn_pkg::*;
#(
  parameter int unsigned FRAC_SHIFT = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    en_i,
  input  logic [PIX_W-1:0]        pix_a_i,
  input  logic [PIX_W-1:0]        pix_b_i,
  input  logic signed [WGT_W-1:0] wgt_a_i,
  input  logic signed [WGT_W-1:0] wgt_b_i,
  output logic signed [RES_W-1:0] result_o
);

  localparam logic signed [ACC_W-1:0] SatMax = ACC_W'(2 ** (RES_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

  // valid_q[0]: memory data valid this cycle; valid_q[1]: products valid this cycle.
  logic [1:0]               valid_d, valid_q;
  logic signed [PROD_W-1:0] prod_a_d, prod_a_q, prod_b_d, prod_b_q;
  logic signed [PROD_W-1:0] pix_a_ext, pix_b_ext, wgt_a_ext, wgt_b_ext;
  logic signed [ACC_W-1:0]  acc_d, acc_q, shifted;

  always_comb begin
    pix_a_ext = PROD_W'($signed({1'b0, pix_a_i}));
    pix_b_ext = PROD_W'($signed({1'b0, pix_b_i}));
    wgt_a_ext = PROD_W'(wgt_a_i);
    wgt_b_ext = PROD_W'(wgt_b_i);
    valid_d   = {valid_q[0], en_i};
    prod_a_d  = prod_a_q;
    prod_b_d  = prod_b_q;
    if (valid_q[0]) begin
      prod_a_d = pix_a_ext * wgt_a_ext;
      prod_b_d = pix_b_ext * wgt_b_ext;
    end
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (valid_q[1]) begin
      acc_d = acc_q + ACC_W'(prod_a_q) + ACC_W'(prod_b_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      prod_a_q <= '0;
      prod_b_q <= '0;
      acc_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      prod_a_q <= prod_a_d;
      prod_b_q <= prod_b_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    shifted = acc_q >>> FRAC_SHIFT;
    if (shifted > SatMax) begin
      result_o = SatMax[RES_W-1:0];
    end else if (shifted < SatMin) begin
      result_o = SatMin[RES_W-1:0];
    end else begin
      result_o = shifted[RES_W-1:0];
    end
  end

endmodule

// File: rtl/nn_row_sequencer.sv
// Row sequencer for the output layer: issues pixel/weight pair reads, drains the MAC
// pipeline, writes one saturated result per row and pulses done_calc at the end.
module nn_row_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned FRAC_SHIFT = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_calc,
  output logic [PIX_AW-1:0] pixel_address_1,
  output logic [PIX_AW-1:0] pixel_address_2,
  output logic [WGT_AW-1:0] weight_address_1,
  output logic [WGT_AW-1:0] weight_address_2,
  input  logic [PIX_W-1:0]  pixel_value_1,
  input  logic [PIX_W-1:0]  pixel_value_2,
  input  logic [WGT_W-1:0]  weight_value_1,
  input  logic [WGT_W-1:0]  weight_value_2,
  output logic              result_wen,
  output logic [ROW_AW-1:0] result_addr,
  output logic [RES_W-1:0]  result_data,
  output logic              busy,
  output logic              done_calc
);

  localparam logic [PAIR_W-1:0] KLast = PAIR_W'(NUM_PIXELS / 2 - 1);
  localparam logic [ROW_AW-1:0] RowLast = ROW_AW'(NUM_ROWS - 1);

  seq_state_t        state_d, state_q;
  logic [ROW_AW-1:0] row_d, row_q;
  // Pair index while issuing, reused as the drain cycle counter.
  logic [PAIR_W-1:0] k_d, k_q;
  logic [WGT_AW-1:0] wbase_d, wbase_q;
  logic              issue, writing;
  logic signed [RES_W-1:0] sat_result;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    wbase_d = wbase_q;
    unique case (state_q)
      IDLE: begin
        if (start_calc) begin
          state_d = ISSUE;
          row_d   = '0;
          k_d     = '0;
          wbase_d = '0;
        end
      end
      ISSUE: begin
        if (k_q == KLast) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + PAIR_W'(1);
        end
      end
      DRAIN: begin
        if (k_q == PAIR_W'(1)) begin
          state_d = WRITE;
          k_d     = '0;
        end else begin
          k_d = k_q + PAIR_W'(1);
        end
      end
      WRITE: begin
        if (row_q == RowLast) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
          row_d   = row_q + ROW_AW'(1);
          wbase_d = wbase_q + WGT_AW'(NUM_PIXELS);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      k_q     <= '0;
      wbase_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      wbase_q <= wbase_d;
    end
  end

  always_comb begin
    issue            = (state_q == ISSUE);
    writing          = (state_q == WRITE);
    pixel_address_1  = issue ? {k_q, 1'b0} : '0;
    pixel_address_2  = issue ? {k_q, 1'b1} : '0;
    weight_address_1 = issue ? wbase_q + WGT_AW'({k_q, 1'b0}) : '0;
    weight_address_2 = issue ? wbase_q + WGT_AW'({k_q, 1'b1}) : '0;
    result_wen       = writing;
    result_addr      = writing ? row_q : '0;
    result_data      = writing ? sat_result : '0;
    busy             = (state_q != IDLE);
    done_calc        = (state_q == DONE);
  end

  nn_mac_pair #(
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_mac (
    .clk_i   (clk),
    .rst_ni  (n_rst),
    .clear_i (writing),
    .en_i    (issue),
    .pix_a_i (pixel_value_1),
    .pix_b_i (pixel_value_2),
    .wgt_a_i (weight_value_1),
    .wgt_b_i (weight_value_2),
    .result_o(sat_result)
  );

endmodule

// File: tb/tb_nn_row_sequencer.sv
// Self-checking bench for nn_row_sequencer: synchronous-read memory models, a dot-product
// reference model and a cycle schedule derived from the row timing rules.
module tb_nn_row_sequencer;

  localparam int Rows   = 10;
  localparam int Pixels = 784;
  localparam int Pairs  = Pixels / 2;
  localparam int RowCyc = Pairs + 3;
  localparam int DoneRel = Rows * RowCyc + 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start_calc = 1'b0;
  logic [9:0]  pixel_address_1, pixel_address_2;
  logic [12:0] weight_address_1, weight_address_2;
  logic [7:0]  pixel_value_1 = '0, pixel_value_2 = '0;
  logic [15:0] weight_value_1 = '0, weight_value_2 = '0;
  logic        result_wen, busy, done_calc;
  logic [3:0]  result_addr;
  logic [15:0] result_data;

  logic [9:0]  s_pa1, s_pa2;
  logic [12:0] s_wa1, s_wa2;
  logic        s_wen, s_busy, s_done;
  logic [3:0]  s_addr;
  logic [15:0] s_data;

  logic [7:0]         pix_mem [Pixels];
  logic signed [15:0] wgt_mem [Rows * Pixels];
  longint exp0 [Rows];
  longint exp8 [Rows];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    pixel_value_1  <= pix_mem[pixel_address_1];
    pixel_value_2  <= pix_mem[pixel_address_2];
    weight_value_1 <= wgt_mem[weight_address_1];
    weight_value_2 <= wgt_mem[weight_address_2];
  end

  nn_row_sequencer #(.FRAC_SHIFT(0)) u_dut (
    .clk(clk), .n_rst(n_rst), .start_calc(start_calc),
    .pixel_address_1(pixel_address_1), .pixel_address_2(pixel_address_2),
    .weight_address_1(weight_address_1), .weight_address_2(weight_address_2),
    .pixel_value_1(pixel_value_1), .pixel_value_2(pixel_value_2),
    .weight_value_1(weight_value_1), .weight_value_2(weight_value_2),
    .result_wen(result_wen), .result_addr(result_addr), .result_data(result_data),
    .busy(busy), .done_calc(done_calc)
  );

  // Same stimulus, default scaling; fed by the first instance's identical read schedule.
  nn_row_sequencer #(.FRAC_SHIFT(8)) u_dut8 (
    .clk(clk), .n_rst(n_rst), .start_calc(start_calc),
    .pixel_address_1(s_pa1), .pixel_address_2(s_pa2),
    .weight_address_1(s_wa1), .weight_address_2(s_wa2),
    .pixel_value_1(pixel_value_1), .pixel_value_2(pixel_value_2),
    .weight_value_1(weight_value_1), .weight_value_2(weight_value_2),
    .result_wen(s_wen), .result_addr(s_addr), .result_data(s_data),
    .busy(s_busy), .done_calc(s_done)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint model(int r, int sh);
    longint s = 0;
    for (int i = 0; i < Pixels; i++) s += longint'(pix_mem[i]) * longint'(wgt_mem[r * Pixels + i]);
    s = s >>> sh;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // 0 ones, 1 max weights, 2 min weights, 3 per-row ramp, 4 random full, 5 random small.
  task automatic fill(int mode);
    for (int i = 0; i < Pixels; i++) begin
      case (mode)
        0, 3:    pix_mem[i] = 8'd1;
        1, 2:    pix_mem[i] = 8'd255;
        default: pix_mem[i] = 8'($urandom);
      endcase
    end
    for (int i = 0; i < Rows * Pixels; i++) begin
      case (mode)
        0:       wgt_mem[i] = 16'sd1;
        1:       wgt_mem[i] = 16'sd32767;
        2:       wgt_mem[i] = -16'sd32768;
        3:       wgt_mem[i] = 16'(i / Pixels + 1);
        4:       wgt_mem[i] = 16'($urandom);
        default: wgt_mem[i] = 16'(int'($urandom_range(0, 255)) - 128);
      endcase
    end
    for (int r = 0; r < Rows; r++) begin
      exp0[r] = model(r, 0);
      exp8[r] = model(r, 8);
    end
  endtask

  // One full calculation; extra start pulses at pulse_a/pulse_b, reset at abort_rel.
  task automatic run(string tag, int mode, int pulse_a, int pulse_b, int abort_rel);
    int s, rel, row, ph, pa, wa;
    bit iss, wen_e;
    fill(mode);
    @(negedge clk);
    s = cyc;
    start_calc = 1'b1;
    for (int i = 0; i < DoneRel + 3; i++) begin
      @(negedge clk);
      start_calc = 1'b0;
      rel = cyc - s;
      if (rel == abort_rel) begin
        n_rst = 1'b0;
        #1;
        check({tag, ":rst_addr"}, 64'({pixel_address_1, pixel_address_2,
                                       weight_address_1, weight_address_2}), 64'd0);
        check({tag, ":rst_out"}, 64'({result_wen, result_addr, result_data, busy, done_calc}),
              64'd0);
        repeat (4) begin
          @(negedge clk);
          check({tag, ":rst_hold"}, 64'({result_wen, s_wen, busy, done_calc}), 64'd0);
        end
        n_rst = 1'b1;
        return;
      end
      row   = (rel - 1) / RowCyc;
      ph    = (rel - 1) % RowCyc;
      iss   = (rel < DoneRel) && (ph < Pairs);
      wen_e = (rel < DoneRel) && (ph == RowCyc - 1);
      pa    = iss ? 2 * ph : 0;
      wa    = iss ? row * Pixels + 2 * ph : 0;
      check({tag, ":busy"}, 64'(busy), 64'(rel <= DoneRel));
      check({tag, ":done"}, 64'(done_calc), 64'(rel == DoneRel));
      check({tag, ":wen"}, 64'({result_wen, s_wen}), 64'({wen_e, wen_e}));
      check({tag, ":addr"}, 64'({pixel_address_1, pixel_address_2, weight_address_1,
                                weight_address_2}),
            64'({10'(pa), 10'(iss ? pa + 1 : 0), 13'(wa), 13'(iss ? wa + 1 : 0)}));
      if (wen_e) begin
        check({tag, ":row"}, 64'(result_addr), 64'(row));
        check({tag, ":data"}, $signed(result_data), exp0[row]);
        check({tag, ":data_shift8"}, $signed(s_data), exp8[row]);
      end
      if (rel == pulse_a || rel == pulse_b) start_calc = 1'b1;
    end
  endtask

  initial begin
    #1;
    check("reset_addr", 64'({pixel_address_1, pixel_address_2, weight_address_1,
                             weight_address_2}), 64'd0);
    check("reset_out", 64'({result_wen, result_addr, result_data, busy, done_calc}), 64'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    run("ones", 0, -1, -1, -1);
    run("sat_hi", 1, -1, -1, -1);
    run("sat_lo", 2, -1, -1, -1);
    run("ramp", 3, -1, -1, -1);
    run("rand_ignore_start", 4, 3 * RowCyc + 100, DoneRel, -1);
    run("rand_small", 5, -1, -1, -1);
    run("abort_row5", 0, -1, -1, 5 * RowCyc + 200);
    run("after_abort", 0, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
